status_annunciator: RTL and testbench
=====================================

# status_annunciator

Scheduler that shares the board's seven-segment display and speaker between several result producers (encrypt core, decrypt core, UART link). Each requester posts a status message with a display time in milliseconds. The block grants requests round-robin and holds each message for its full duration, followed by a silent gap. It drives the digit, enable and note inputs of `DisplayControl` and `SpeakerControl`, and shows SAFE when idle.

## Interface
- `NUM_REQ`, 3: number of requesters, 2..8.
- `TICK_DIV`, 100_000: clk cycles per millisecond tick (100 MHz board).
- `GAP_MS`, 50: silent SAFE gap after every message, in ms; must be ≥ 1.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in NUM_REQ: per-requester request level, held until `ack`.
- `msg_code` in 2·NUM_REQ: 2-bit code per requester, slice i = [2i+1:2i]. 0 = SAFE, 1 = PASS, 2 = FAIL, 3 = reserved (shown as FAIL).
- `dur_ms` in 16·NUM_REQ: display time per requester; 0 is treated as 1.
- `flush` in 1: abort the current message and return to IDLE.
- `ack` out NUM_REQ: one-cycle grant pulse, one-hot.
- `busy` out 1: high in SHOW and GAP.
- `digit3`, `digit2`, `digit1`, `digit0` out 5 each: glyph indices to `DisplayControl`.
- `enables` out 4: digit enables.
- `note` out 5: tone select to `SpeakerControl`.

## Operation
- FSM states: IDLE, SHOW, GAP.
- **IDLE**
  - Outputs show SAFE with note 5'b00000.
  - On any `req` bit set and `flush` low: pick the winner round-robin, starting from the index after the last grant.
  - Pulse `ack[winner]`, latch its code and duration, clear the tick prescaler, go to SHOW.
- **SHOW**
  - Outputs show the latched message.
  - Remaining-ms counter decrements on each tick. When the counter reaches 0 at a tick, go to GAP and load `GAP_MS`.
- **GAP**
  - Outputs show SAFE with note 0.
  - Decrement on each tick. At 0, go to IDLE.
- `flush` in SHOW or GAP: go to IDLE on the next edge; outputs show SAFE.
  - `flush` wins over a simultaneous `req`: no `ack` that cycle.
- Message mapping:
  - SAFE: digits 5,10,15,14; note 5'b00000.
  - PASS: digits 15,10,5,5; note 5'b11110.
  - FAIL: digits 15,10,1,1; note 5'b11111.
  - `enables` = 4'b1111 in every state.
- Requests arriving in SHOW or GAP wait. Nothing is queued beyond the held `req` levels.
- A requester that drops `req` before `ack` loses its turn silently.
- Round-robin pointer reset value is NUM_REQ-1, so requester 0 has first priority after reset.

## Timing
- Reset values:
  - state IDLE, `ack` = 0, `busy` = 0.
  - digits 5,10,15,14 (SAFE), `enables` = 4'b1111, `note` = 0.
  - pointer NUM_REQ-1, counters 0.
- All outputs are registered.
- `req` sampled high at edge N in IDLE: `ack`, `busy` = 1 and the new digits/note all appear after edge N, in the same cycle.
- SHOW lasts exactly max(dur_ms,1)·TICK_DIV cycles. The prescaler restarts on grant, so there is no ±1 ms jitter.
- GAP lasts exactly GAP_MS·TICK_DIV cycles.
- IDLE lasts at least 1 cycle between messages, so the grant-to-grant minimum is (dur + GAP_MS)·TICK_DIV + 1 cycles.
- `ack` is never high for two consecutive cycles.
- `rst` asserted mid-SHOW: all outputs return to reset values immediately, asynchronously, and the in-flight message is dropped.
- Counter widths: ms counter 16 bits, with no wrap because the load is ≥ 1. Prescaler is $clog2(TICK_DIV) bits and wraps at TICK_DIV-1.

## Structure
- Package `anubis_status_pkg` holds:
  - message code constants (MSG_SAFE, MSG_PASS, MSG_FAIL);
  - glyph index constants;
  - note constants (NOTE_OFF = 5'b00000, NOTE_PASS = 5'b11110, NOTE_FAIL = 5'b11111);
  - the FSM state enum.
- Sub-module `ms_tick_gen`:
  - ports `clk`, `rst`, `clr`, `tick`;
  - `tick` is a one-cycle pulse every TICK_DIV cycles after `clr`.
- The round-robin pick stays inline as a function.

## Test plan
Run with TICK_DIV = 4, GAP_MS = 2, NUM_REQ = 3.
- Reset, then idle: digits 5,10,15,14, `note` = 0, `busy` = 0, `ack` = 0.
- req[1] with PASS, dur 3: `ack` = 3'b010 one cycle later, together with digits 15,10,5,5 and `note` 5'b11110. Message held exactly 12 cycles, then SAFE for 8 cycles, then `busy` = 0.
- req = 3'b111 held, all FAIL, dur 1: grants come in order 0, 1, 2, 0. Each `ack` is exactly 4 + 8 + 1 = 13 cycles after the previous one.
- dur_ms = 0 with code 3: shows FAIL digits 15,10,1,1 with `note` 5'b11111 for 4 cycles.
- `flush` on SHOW cycle 2 while req[2] is pending: SAFE and `busy` = 0 next cycle with no `ack` that cycle; req[2] is acked one cycle later.
- `rst` pulsed mid-GAP: outputs return to reset values without waiting for a clock edge; the pointer restarts so requester 0 wins the next arbitration.

Source files
------------

// File: rtl/status_annunciator_pkg.sv
// Shared constants for the status annunciator: message codes, display glyphs,
// speaker notes, FSM states and the code-to-display mapping.
package anubis_status_pkg;

  localparam logic [1:0] MSG_SAFE = 2'd0;
  localparam logic [1:0] MSG_PASS = 2'd1;
  localparam logic [1:0] MSG_FAIL = 2'd2;

  // DisplayControl glyph indices; P and F share the same glyph slot.
  localparam logic [4:0] GLYPH_S = 5'd5;
  localparam logic [4:0] GLYPH_A = 5'd10;
  localparam logic [4:0] GLYPH_F = 5'd15;
  localparam logic [4:0] GLYPH_P = 5'd15;
  localparam logic [4:0] GLYPH_E = 5'd14;
  localparam logic [4:0] GLYPH_1 = 5'd1;

  localparam logic [4:0] NOTE_OFF  = 5'b00000;
  localparam logic [4:0] NOTE_PASS = 5'b11110;
  localparam logic [4:0] NOTE_FAIL = 5'b11111;

  localparam logic [3:0] ENABLES_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0] d3;
    logic [4:0] d2;
    logic [4:0] d1;
    logic [4:0] d0;
    logic [4:0] note;
  } face_t;

  // Reserved code 3 is deliberately shown as FAIL.
  function automatic face_t msg_face(input logic [1:0] code);
    face_t f;
    case (code)
      MSG_SAFE: f = '{GLYPH_S, GLYPH_A, GLYPH_F, GLYPH_E, NOTE_OFF};
      MSG_PASS: f = '{GLYPH_P, GLYPH_A, GLYPH_S, GLYPH_S, NOTE_PASS};
      default:  f = '{GLYPH_F, GLYPH_A, GLYPH_1, GLYPH_1, NOTE_FAIL};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/status_annunciator_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV cycles, phase-reset by clr
// so a freshly granted message always gets whole milliseconds.
module ms_tick_gen #(
  parameter int TICK_DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/status_annunciator.sv
// Round-robin scheduler sharing the seven-segment display and speaker between
// result producers; each message is held for its duration, then a SAFE gap.
module status_annunciator
  import anubis_status_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int TICK_DIV = 100_000,
  parameter int GAP_MS   = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [2*NUM_REQ-1:0]    msg_code,
  input  logic [16*NUM_REQ-1:0]   dur_ms,
  input  logic                    flush,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    busy,
  output logic [4:0]              digit3,
  output logic [4:0]              digit2,
  output logic [4:0]              digit1,
  output logic [4:0]              digit0,
  output logic [3:0]              enables,
  output logic [4:0]              note
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] GAP_LOAD = 16'(GAP_MS);
  localparam logic [PW-1:0] PTR_RESET = PW'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [15:0]         rem_q, rem_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;
  face_t               face_q, face_d;

  logic                clr;
  logic                tick;
  logic [PW:0]         pick;
  logic [PW-1:0]       win;
  logic [1:0]          win_code;
  logic [15:0]         win_dur;

  // Candidates are visited farthest-first so the nearest one after 'last' wins.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                          input logic [PW-1:0] last);
    logic [PW:0] sel;
    int idx;
    sel = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (r[PW'(idx)]) begin
        sel = {1'b1, PW'(idx)};
      end
    end
    return sel;
  endfunction

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    pick     = rr_pick(req, ptr_q);
    win      = pick[PW-1:0];
    win_code = msg_code[2*int'(win) +: 2];
    win_dur  = dur_ms[16*int'(win) +: 16];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    ack_d   = '0;
    busy_d  = busy_q;
    face_d  = face_q;
    clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        face_d = msg_face(MSG_SAFE);
        if (pick[PW] && !flush) begin
          state_d     = ST_SHOW;
          ptr_d       = win;
          ack_d[win]  = 1'b1;
          rem_d       = (win_dur == 16'd0) ? 16'd1 : win_dur;
          busy_d      = 1'b1;
          face_d      = msg_face(win_code);
          clr         = 1'b1;
        end
      end
      ST_SHOW: begin
        if (tick) begin
          if (rem_q <= 16'd1) begin
            state_d = ST_GAP;
            rem_d   = GAP_LOAD;
            face_d  = msg_face(MSG_SAFE);
          end else begin
            rem_d = rem_q - 16'd1;
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (rem_q <= 16'd1) begin
            state_d = ST_IDLE;
            rem_d   = 16'd0;
            busy_d  = 1'b0;
          end else begin
            rem_d = rem_q - 16'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = 16'd0;
        busy_d  = 1'b0;
        face_d  = msg_face(MSG_SAFE);
      end
    endcase

    // An abort drops whatever is on screen; in IDLE it merely blocks the grant.
    if (flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      rem_d   = 16'd0;
      busy_d  = 1'b0;
      face_d  = msg_face(MSG_SAFE);
      ack_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RESET;
      rem_q   <= 16'd0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      face_q  <= msg_face(MSG_SAFE);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      face_q  <= face_d;
    end
  end

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign digit3  = face_q.d3;
  assign digit2  = face_q.d2;
  assign digit1  = face_q.d1;
  assign digit0  = face_q.d0;
  assign note    = face_q.note;
  assign enables = ENABLES_ALL;

endmodule

// File: tb/tb_status_annunciator.sv
// Directed plus randomized bench for status_annunciator; expected behaviour comes
// from a timeline model of the message/gap/idle sequence and a round-robin pick.
module tb_status_annunciator;

  localparam int NUM_REQ  = 3;
  localparam int TICK_DIV = 4;
  localparam int GAP_MS   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req;
  logic [2*NUM_REQ-1:0]  msg_code;
  logic [16*NUM_REQ-1:0] dur_ms;
  logic                  flush;
  logic [NUM_REQ-1:0]    ack;
  logic                  busy;
  logic [4:0]            digit3, digit2, digit1, digit0;
  logic [3:0]            enables;
  logic [4:0]            note;

  int compared   = 0;
  int mismatched = 0;
  int last_grant = NUM_REQ - 1;

  always #5 clk = ~clk;

  status_annunciator #(
    .NUM_REQ  (NUM_REQ),
    .TICK_DIV (TICK_DIV),
    .GAP_MS   (GAP_MS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .msg_code (msg_code),
    .dur_ms   (dur_ms),
    .flush    (flush),
    .ack      (ack),
    .busy     (busy),
    .digit3   (digit3),
    .digit2   (digit2),
    .digit1   (digit1),
    .digit0   (digit0),
    .enables  (enables),
    .note     (note)
  );

  function automatic logic [24:0] expFace(input logic [1:0] code);
    case (code)
      2'd0:    return {5'd5,  5'd10, 5'd15, 5'd14, 5'b00000};
      2'd1:    return {5'd15, 5'd10, 5'd5,  5'd5,  5'b11110};
      default: return {5'd15, 5'd10, 5'd1,  5'd1,  5'b11111};
    endcase
  endfunction

  function automatic int modelWinner(input logic [NUM_REQ-1:0] r);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last_grant + k) % NUM_REQ]) return (last_grant + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [NUM_REQ-1:0] expAck,
                             input logic expBusy, input logic [1:0] code);
    logic [32:0] obs;
    logic [32:0] exp;
    obs = {ack, busy, enables, digit3, digit2, digit1, digit0, note};
    exp = {expAck, expBusy, 4'b1111, expFace(code)};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [1:0] code, input logic [15:0] dur);
    msg_code[2*r +: 2] = code;
    dur_ms[16*r +: 16] = dur;
    req[r]             = 1'b1;
  endtask

  // Grant expected at the next edge, then dur ms of message, GAP_MS of SAFE, one IDLE cycle.
  task automatic runMessage(input string tag, input int w, input bit hold);
    logic [1:0]  code;
    logic [15:0] dur;
    int          eff;
    code = msg_code[2*w +: 2];
    dur  = dur_ms[16*w +: 16];
    eff  = (dur == 16'd0) ? 1 : int'(dur);
    step;
    checkOutput({tag, "/ack"}, NUM_REQ'(1 << w), 1'b1, code);
    last_grant = w;
    if (!hold) req = '0;
    for (int c = 1; c < eff * TICK_DIV; c++) begin
      step;
      checkOutput({tag, "/show"}, '0, 1'b1, code);
    end
    for (int c = 0; c < GAP_MS * TICK_DIV; c++) begin
      step;
      checkOutput({tag, "/gap"}, '0, 1'b1, 2'd0);
    end
    step;
    checkOutput({tag, "/idle"}, '0, 1'b0, 2'd0);
  endtask

  initial begin
    int w;
    logic [NUM_REQ-1:0] rv;

    rst      = 1'b1;
    req      = '0;
    msg_code = '0;
    dur_ms   = '0;
    flush    = 1'b0;
    #2;
    checkOutput("reset/async", '0, 1'b0, 2'd0);
    step;
    step;
    rst = 1'b0;
    step;
    checkOutput("reset/idle", '0, 1'b0, 2'd0);

    $display("[TB] round robin with all requesters held");
    for (int r = 0; r < NUM_REQ; r++) applyStimulus(r, 2'd2, 16'd1);
    runMessage("rr0", 0, 1'b1);
    runMessage("rr1", 1, 1'b1);
    runMessage("rr2", 2, 1'b1);
    runMessage("rr3", 0, 1'b0);

    $display("[TB] single PASS message");
    applyStimulus(1, 2'd1, 16'd3);
    runMessage("pass3", modelWinner(req), 1'b0);

    $display("[TB] zero duration with reserved code");
    applyStimulus(0, 2'd3, 16'd0);
    runMessage("dur0", modelWinner(req), 1'b0);

    $display("[TB] flush during SHOW");
    applyStimulus(0, 2'd1, 16'd3);
    w = modelWinner(req);
    step;
    checkOutput("flush/ack", NUM_REQ'(1 << w), 1'b1, 2'd1);
    last_grant = w;
    req = '0;
    step;
    checkOutput("flush/show2", '0, 1'b1, 2'd1);
    applyStimulus(2, 2'd2, 16'd1);
    flush = 1'b1;
    step;
    checkOutput("flush/abort", '0, 1'b0, 2'd0);
    flush = 1'b0;
    runMessage("flush/next", modelWinner(req), 1'b0);

    $display("[TB] randomized requests");
    for (int it = 0; it < 8; it++) begin
      rv = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int r = 0; r < NUM_REQ; r++) begin
        if (rv[r]) applyStimulus(r, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 2)));
      end
      runMessage("rand", modelWinner(req), 1'b0);
    end

    $display("[TB] reset during GAP");
    applyStimulus(1, 2'd1, 16'd1);
    w = modelWinner(req);
    step;
    checkOutput("rstgap/ack", NUM_REQ'(1 << w), 1'b1, 2'd1);
    req = '0;
    for (int c = 1; c < TICK_DIV; c++) begin
      step;
      checkOutput("rstgap/show", '0, 1'b1, 2'd1);
    end
    for (int c = 0; c < 3; c++) begin
      step;
      checkOutput("rstgap/gap", '0, 1'b1, 2'd0);
    end
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstgap/async", '0, 1'b0, 2'd0);
    step;
    rst = 1'b0;
    last_grant = NUM_REQ - 1;
    applyStimulus(0, 2'd2, 16'd1);
    applyStimulus(2, 2'd1, 16'd1);
    runMessage("rstgap/next", modelWinner(req), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
